cia_sp_link: RTL and testbench
==============================

CIA_SP_LINK -- requirements
Module: cia_sp_link

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 8: CNT half-period in clk cycles, minimum 2.
REQ-002 SHALL have parameter GAP_CYCLES, default 16: idle guard time after each transmitted byte, in clk cycles.
REQ-003 SHALL have parameter RX_TIMEOUT, default 1024: clk cycles without a CNT rising edge before a partial receive byte is discarded.
REQ-004 Ports, one per line:
- clk  input  1  single system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_data  input  8  byte to send to the peer, MSB first.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  block can accept a byte.
- rx_data  output  8  last byte received from the peer.
- rx_valid  output  1  rx_data holds an unacknowledged byte.
- rx_ack  input  1  consumer takes rx_data.
- rx_overrun  output  1  sticky: a byte arrived while rx_valid was high.
- cnt_in  input  1  CNT line from peer (asynchronous).
- sp_in  input  1  SP line from peer (asynchronous).
- cnt_out  output  1  CNT driven by this block.
- sp_out  output  1  SP driven by this block.
- cnt_oe  output  1  this block owns CNT/SP lines.

Function
REQ-005 SHALL synchronise cnt_in and sp_in through two flip-flops each before use.
REQ-006 SHALL detect a CNT rising edge as synchronised CNT high while its registered previous value is low.
REQ-007 TX FSM states SHALL be IDLE, LOW, HIGH, GAP.
REQ-008 tx_ready SHALL be high exactly when state is IDLE; a transfer is accepted on a cycle with tx_valid and tx_ready both high.
REQ-009 On acceptance: next state LOW, shift register loaded with tx_data, bit counter 0, cnt_oe high.
REQ-010 In LOW: cnt_out 0, sp_out = current MSB, held HALF_PERIOD cycles, then HIGH.
REQ-011 In HIGH: cnt_out 1, sp_out unchanged, held HALF_PERIOD cycles; then shift left one bit; after the 8th HIGH go to GAP, otherwise LOW.
REQ-012 In GAP: cnt_out 1, sp_out 1, cnt_oe high, held GAP_CYCLES cycles, then IDLE with cnt_oe low.
REQ-013 Byte occupancy SHALL be exactly 16*HALF_PERIOD + GAP_CYCLES cycles from acceptance to tx_ready high.
REQ-014 Receiver SHALL shift synchronised SP into an 8-bit register, MSB first, on each CNT rising edge while cnt_oe is low.
REQ-015 Receiver SHALL ignore CNT edges while cnt_oe is high and SHALL clear its bit count when cnt_oe rises.
REQ-016 On the 8th bit the byte SHALL be written to rx_data and rx_valid set on the following cycle, i.e. 4 clk cycles after the clk edge that first samples raw cnt_in high.
REQ-017 rx_ack with rx_valid high SHALL clear rx_valid and rx_overrun next cycle.
REQ-018 Byte completion while rx_valid is high and rx_ack is low SHALL overwrite rx_data, keep rx_valid high and set rx_overrun.
REQ-019 Byte completion in the same cycle as rx_ack SHALL leave rx_valid high with the new byte and not set rx_overrun.
REQ-020 With 1-7 bits collected and no CNT rising edge for RX_TIMEOUT cycles, bit count SHALL reset to 0 with no rx_valid.
REQ-021 tx_valid while tx_ready is low SHALL be ignored; tx_data is sampled only at acceptance.

Reset
REQ-022 While reset is high: state IDLE, tx_ready 1, cnt_out 1, sp_out 1, cnt_oe 0, rx_valid 0, rx_overrun 0, rx_data 0x00, all counters, shift and synchroniser registers 0.
REQ-023 Reset mid-transfer SHALL immediately release the lines (cnt_oe 0) and discard any partial TX or RX byte.

Structure
REQ-024 Shared package cia_pkg SHALL hold the TX state enum and default parameter constants (HALF_PERIOD, GAP_CYCLES, RX_TIMEOUT).
REQ-025 The two-flop synchroniser SHALL be sub-module cia_sync2, instantiated twice; TX and RX logic remain in cia_sp_link.

Verification (HALF_PERIOD=4, GAP_CYCLES=8)
REQ-026 Send 0xA5 -> 8 cnt_out rising edges; sp_out at each edge 1,0,1,0,0,1,0,1; tx_ready low 72 cycles; cnt_oe then low.
REQ-027 Peer model clocks 0x3C (period 20 cycles) -> rx_valid high 4 cycles after last raw edge, rx_data 0x3C, rx_overrun 0; rx_ack clears rx_valid.
REQ-028 Peer sends 0x11 then 0x22 with no rx_ack -> rx_data 0x22, rx_valid 1, rx_overrun 1; rx_ack clears both.
REQ-029 Peer sends 3 bits, idles RX_TIMEOUT+2 cycles, then sends 0x81 -> rx_data 0x81, no spurious byte.
REQ-030 Reset asserted 20 cycles into a 0xFF transmit -> cnt_out 1, sp_out 1, cnt_oe 0, tx_ready 1 asynchronously; next send 0x00 completes normally.
REQ-031 Back-to-back tx_valid with 0x01, 0x80 -> second accepted exactly on the cycle tx_ready returns; peer edges during TX produce no rx_valid.

Source files
------------

// File: rtl/cia_pkg.sv
// Shared types and default timing constants for the CIA serial-port link.
// Imported by the link top and its synchroniser.
package cia_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOW,
        TX_HIGH,
        TX_GAP
    } tx_state_e;

    localparam int HALF_PERIOD = 8;
    localparam int GAP_CYCLES  = 16;
    localparam int RX_TIMEOUT  = 1024;

    localparam int CNT_W = 16;

endpackage

// File: rtl/cia_sp_link_if.sv
// Bundle of the byte handshakes and serial line pins of cia_sp_link.
// master = host/peer side that drives the link, slave = the link itself.
interface cia_sp_link_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_overrun;
    logic       cnt_in;
    logic       sp_in;
    logic       cnt_out;
    logic       sp_out;
    logic       cnt_oe;

    modport master (
        output tx_data, tx_valid, rx_ack, cnt_in, sp_in,
        input  tx_ready, rx_data, rx_valid, rx_overrun,
        input  cnt_out, sp_out, cnt_oe
    );

    modport slave (
        input  tx_data, tx_valid, rx_ack, cnt_in, sp_in,
        output tx_ready, rx_data, rx_valid, rx_overrun,
        output cnt_out, sp_out, cnt_oe
    );

endinterface

// File: rtl/cia_sync2.sv
// Two-flop synchroniser for an asynchronous input line.
// Output is the second stage; both stages clear on reset.
module cia_sync2
    import cia_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    // next values: shift the line through the two stages
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // synchroniser stages
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/cia_sp_link.sv
// CIA-style serial port link: MSB-first byte transmitter that drives CNT/SP,
// and a receiver that shifts SP on peer CNT rising edges when not driving.
module cia_sp_link
    import cia_pkg::*;
#(
    parameter int HALF_PERIOD = cia_pkg::HALF_PERIOD,
    parameter int GAP_CYCLES  = cia_pkg::GAP_CYCLES,
    parameter int RX_TIMEOUT  = cia_pkg::RX_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_overrun,
    input  logic       cnt_in,
    input  logic       sp_in,
    output logic       cnt_out,
    output logic       sp_out,
    output logic       cnt_oe
);

    localparam logic [CNT_W-1:0] HP_LAST  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(RX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic cnt_s;
    logic sp_s;

    cia_sync2 u_sync_cnt (
        .clk   (clk),
        .reset (reset),
        .d     (cnt_in),
        .q     (cnt_s)
    );

    cia_sync2 u_sync_sp (
        .clk   (clk),
        .reset (reset),
        .d     (sp_in),
        .q     (sp_s)
    );

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;

    // transmit sequencing: half-period LOW/HIGH per bit, then guard gap
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            TX_IDLE: begin
                if (tx_valid) begin
                    state_d = TX_LOW;
                    shift_d = tx_data;
                    bit_d   = 3'd0;
                    div_d   = '0;
                end
            end
            TX_LOW: begin
                if (div_q == HP_LAST) begin
                    div_d   = '0;
                    state_d = TX_HIGH;
                end else begin
                    div_d = div_q + ONE;
                end
            end
            TX_HIGH: begin
                if (div_q == HP_LAST) begin
                    div_d   = '0;
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    state_d = (bit_q == 3'd7) ? TX_GAP : TX_LOW;
                end else begin
                    div_d = div_q + ONE;
                end
            end
            TX_GAP: begin
                if (div_q == GAP_LAST) begin
                    div_d   = '0;
                    state_d = TX_IDLE;
                end else begin
                    div_d = div_q + ONE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // line outputs decode straight from state so reset releases them at once
    always_comb begin
        tx_ready = (state_q == TX_IDLE);
        cnt_oe   = (state_q != TX_IDLE);
        cnt_out  = (state_q != TX_LOW);
        sp_out   = 1'b1;
        if (state_q == TX_LOW || state_q == TX_HIGH) begin
            sp_out = shift_q[7];
        end
    end

    // transmit state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TX_IDLE;
            div_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    logic             cnt_prev_q, cnt_prev_d;
    logic             rise_q, rise_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic             done_q, done_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_ovr_q, rx_ovr_d;

    // receive: edge detect, bit collection, stall timeout, byte hand-off
    always_comb begin
        cnt_prev_d = cnt_s;
        rise_d     = cnt_s & ~cnt_prev_q;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        idle_d     = idle_q;
        done_d     = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;

        if (cnt_oe) begin
            rx_bit_d = 3'd0;
            idle_d   = '0;
        end else if (rise_q) begin
            rx_shift_d = {rx_shift_q[6:0], sp_s};
            rx_bit_d   = rx_bit_q + 3'd1;
            idle_d     = '0;
            done_d     = (rx_bit_q == 3'd7);
        end else if (rx_bit_q != 3'd0) begin
            if (idle_q == TO_LAST) begin
                rx_bit_d = 3'd0;
                idle_d   = '0;
            end else begin
                idle_d = idle_q + ONE;
            end
        end else begin
            idle_d = '0;
        end

        if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            rx_ovr_d   = 1'b0;
        end
        if (done_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ack) begin
                rx_ovr_d = 1'b1;
            end
        end
    end

    // receive state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_prev_q <= 1'b0;
            rise_q     <= 1'b0;
            rx_shift_q <= 8'h00;
            rx_bit_q   <= 3'd0;
            idle_q     <= '0;
            done_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            cnt_prev_q <= cnt_prev_d;
            rise_q     <= rise_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            idle_q     <= idle_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = rx_ovr_q;

endmodule

// File: tb/tb_cia_sp_link.sv
// Randomised bench for cia_sp_link against a cycle-count reference model.
// A peer task drives CNT/SP; a negedge process compares every cycle.
module tb_cia_sp_link;

    localparam int HP   = 4;
    localparam int GC   = 8;
    localparam int TO   = 1024;
    localparam int BUSY = 16 * HP + GC;

    logic clk = 1'b0;
    logic reset = 1'b0;

    cia_sp_link_if bus();

    cia_sp_link #(
        .HALF_PERIOD (HP),
        .GAP_CYCLES  (GC),
        .RX_TIMEOUT  (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (bus.tx_data),
        .tx_valid   (bus.tx_valid),
        .tx_ready   (bus.tx_ready),
        .rx_data    (bus.rx_data),
        .rx_valid   (bus.rx_valid),
        .rx_ack     (bus.rx_ack),
        .rx_overrun (bus.rx_overrun),
        .cnt_in     (bus.cnt_in),
        .sp_in      (bus.sp_in),
        .cnt_out    (bus.cnt_out),
        .sp_out     (bus.sp_out),
        .cnt_oe     (bus.cnt_oe)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // reference model state
    typedef struct {
        int         due;
        logic [7:0] b;
    } pend_t;

    int         cyc = 0;
    int         age = 0;
    logic [7:0] tx_byte = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;
    logic [7:0] m_data = 8'h00;
    pend_t      pq[$];
    int         last_rise = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            age = 0;
            m_valid = 1'b0;
            m_ovr = 1'b0;
            m_data = 8'h00;
            pq.delete();
        end else begin
            logic pre;
            cyc++;
            if (age == 0) begin
                if (bus.tx_valid) begin
                    age = 1;
                    tx_byte = bus.tx_data;
                end
            end else begin
                age = (age == BUSY) ? 0 : age + 1;
            end
            pre = m_valid;
            if (bus.rx_ack && pre) begin
                m_valid = 1'b0;
                m_ovr = 1'b0;
            end
            if (pq.size() > 0 && pq[0].due == cyc) begin
                if (pre && !bus.rx_ack) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_data = pq[0].b;
                void'(pq.pop_front());
            end
        end
    end

    // expected line state from time since acceptance
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [3:0] e_tx;
            logic [3:0] a_tx;
            logic       e_cnt;
            logic       e_sp;
            if (age == 0) begin
                e_cnt = 1'b1;
                e_sp = 1'b1;
            end else if (age <= 16 * HP) begin
                int p;
                p = (age - 1) / HP;
                e_cnt = (p % 2) == 1;
                e_sp = tx_byte[7 - p / 2];
            end else begin
                e_cnt = 1'b1;
                e_sp = 1'b1;
            end
            e_tx = {age == 0, age != 0, e_cnt, e_sp};
            a_tx = {bus.tx_ready, bus.cnt_oe, bus.cnt_out, bus.sp_out};
            chk("tx_lines{ready,oe,cnt,sp}", 32'(a_tx), 32'(e_tx));
            chk("rx{valid,ovr,data}",
                32'({bus.rx_valid, bus.rx_overrun, bus.rx_data}),
                32'({m_valid, m_ovr, m_data}));
        end
    end

    task automatic tx_send(input logic [7:0] b);
        int n;
        n = 0;
        bus.tx_data = b;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        while (!bus.tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("tx_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("tx_idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic peer_send(input logic [7:0] b, input int nbits,
                             input bit expect_byte);
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk);
            #1;
            bus.cnt_in = 1'b0;
            bus.sp_in = b[7 - i];
            repeat (10) @(posedge clk);
            #1;
            bus.cnt_in = 1'b1;
            last_rise = cyc;
            if (i == 7 && expect_byte) pq.push_back('{due: cyc + 5, b: b});
            repeat (9) @(posedge clk);
        end
    endtask

    task automatic ack_pulse();
        @(posedge clk);
        #1;
        bus.rx_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_ack = 1'b0;
    endtask

    initial begin
        logic [7:0] got;
        int edges;
        int lows;
        int n;
        int vcyc;
        logic prev;

        bus.tx_data = 8'h00;
        bus.tx_valid = 1'b0;
        bus.rx_ack = 1'b0;
        bus.cnt_in = 1'b1;
        bus.sp_in = 1'b1;

        #1 reset = 1'b1;
        cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_ready", 32'(bus.tx_ready), 1);
        chk("rst_cnt_out", 32'(bus.cnt_out), 1);
        chk("rst_sp_out", 32'(bus.sp_out), 1);
        chk("rst_cnt_oe", 32'(bus.cnt_oe), 0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 0);
        chk("rst_rx_overrun", 32'(bus.rx_overrun), 0);
        chk("rst_rx_data", 32'(bus.rx_data), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 0xA5: bits at each CNT rise and busy length
        tx_send(8'hA5);
        edges = 0;
        lows = 0;
        got = 8'h00;
        prev = 1'b1;
        repeat (90) begin
            @(negedge clk);
            if (!bus.tx_ready) lows++;
            if (bus.cnt_out && !prev) begin
                edges++;
                got = {got[6:0], bus.sp_out};
            end
            prev = bus.cnt_out;
        end
        chk("a5_cnt_edges", 32'(edges), 8);
        chk("a5_sp_bits", 32'(got), 32'h A5);
        chk("a5_busy_cycles", 32'(lows), 72);
        chk("a5_oe_after", 32'(bus.cnt_oe), 0);
        @(posedge clk);
        #1;

        // peer byte 0x3C: latency and contents
        vcyc = 0;
        fork
            peer_send(8'h3C, 8, 1'b1);
            begin
                n = 0;
                @(negedge clk);
                while (!bus.rx_valid && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 400) chk("rx_valid_timeout", 0, 1);
                vcyc = cyc;
            end
        join
        chk("rx_latency", 32'(vcyc - (last_rise + 1)), 4);
        chk("rx_3c_data", 32'(bus.rx_data), 32'h3C);
        chk("rx_3c_ovr", 32'(bus.rx_overrun), 0);
        ack_pulse();
        @(negedge clk);
        chk("rx_3c_acked", 32'(bus.rx_valid), 0);

        // overrun
        peer_send(8'h11, 8, 1'b1);
        peer_send(8'h22, 8, 1'b1);
        @(negedge clk);
        chk("ovr_data", 32'(bus.rx_data), 32'h22);
        chk("ovr_valid", 32'(bus.rx_valid), 1);
        chk("ovr_flag", 32'(bus.rx_overrun), 1);
        ack_pulse();
        @(negedge clk);
        chk("ovr_clr_valid", 32'(bus.rx_valid), 0);
        chk("ovr_clr_flag", 32'(bus.rx_overrun), 0);

        // partial byte then timeout
        peer_send(8'hE0, 3, 1'b0);
        repeat (TO + 2) @(posedge clk);
        @(negedge clk);
        chk("partial_no_byte", 32'(bus.rx_valid), 0);
        @(posedge clk);
        #1;
        peer_send(8'h81, 8, 1'b1);
        @(negedge clk);
        chk("after_to_data", 32'(bus.rx_data), 32'h81);
        chk("after_to_ovr", 32'(bus.rx_overrun), 0);
        ack_pulse();

        // back-to-back 0x01 then 0x80, peer edges during TX
        @(posedge clk);
        #1;
        bus.tx_data = 8'h01;
        bus.tx_valid = 1'b1;
        fork
            begin
                n = 0;
                @(negedge clk);
                while (!bus.tx_ready && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk);
                #1;
                bus.tx_data = 8'h80;
                lows = 0;
                @(negedge clk);
                while (!bus.tx_ready && lows < 400) begin
                    lows++;
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                bus.tx_valid = 1'b0;
                @(negedge clk);
                chk("b2b_busy_cycles", 32'(lows), 72);
                chk("b2b_second_taken", 32'(bus.tx_ready), 0);
            end
            begin
                repeat (2) @(posedge clk);
                peer_send(8'hFF, 3, 1'b0);
            end
        join
        wait_idle();
        chk("b2b_no_rx", 32'(bus.rx_valid), 0);
        peer_send(8'h5A, 8, 1'b1);
        @(negedge clk);
        chk("post_tx_rx_data", 32'(bus.rx_data), 32'h5A);
        ack_pulse();

        // randomised traffic
        for (int it = 0; it < 8; it++) begin
            int mode;
            tx_send(8'($urandom));
            repeat ($urandom_range(3, 8)) begin
                @(posedge clk);
                #1;
                bus.tx_valid = $urandom_range(0, 1) == 1;
                bus.tx_data = 8'($urandom);
            end
            bus.tx_valid = 1'b0;
            wait_idle();
            mode = $urandom_range(0, 2);
            fork
                peer_send(8'($urandom), 8, 1'b1);
                begin
                    repeat (170) begin
                        @(posedge clk);
                        #1;
                        bus.rx_ack = (mode != 0) &&
                                     ($urandom_range(0, 3) == 0);
                    end
                    bus.rx_ack = 1'b0;
                end
            join
        end

        // reset in the middle of a 0xFF transmit
        tx_send(8'hFF);
        repeat (19) @(posedge clk);
        #1;
        chk("pre_rst_oe", 32'(bus.cnt_oe), 1);
        reset = 1'b1;
        #1;
        chk("async_rst_cnt_out", 32'(bus.cnt_out), 1);
        chk("async_rst_sp_out", 32'(bus.sp_out), 1);
        chk("async_rst_cnt_oe", 32'(bus.cnt_oe), 0);
        chk("async_rst_tx_ready", 32'(bus.tx_ready), 1);
        @(posedge clk);
        #1 reset = 1'b0;
        tx_send(8'h00);
        wait_idle();
        chk("post_rst_oe", 32'(bus.cnt_oe), 0);
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
